traffic_phase_ctrl: RTL and testbench



---
 rtl/traffic_phase_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
//
// Phase sequencer for a two-road intersection (main road, side road) with a
// pedestrian crossing on the main road. The dwell timer counts 1 s ticks from
// tc_timebase. Lamp outputs, phase, remain and rst_q are all registered.
//
// Phase order: MG -> MY -> R1 -> SG -> SY -> R2 -> MG.
// MG has a minimum dwell. After that it holds (extended green) until a side or
// pedestrian request is pending.
//
// Optional feature, guarded by macro FLASH_MODE_EN:
//   Adds the night_flash input and the FLASH phase (encoding 6). The FSM
//   enters FLASH from R2 and leaves to R1. In FLASH, main yellow and side red
//   blink together, toggling once per tick.
//   Without the macro, encoding 6 is illegal and recovers to MG.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   tc_timebase  in   one-cycle 1 s tick
//   side_req     in   side-road vehicle sensor (level)
//   ped_req      in   pedestrian button (level or pulse)
//   night_flash  in   flash-mode request (FLASH_MODE_EN only)
//   main_lt      out  main lamps {R,Y,G}
//   side_lt      out  side lamps {R,Y,G}
//   ped_walk     out  walk lamp
//   phase        out  current phase encoding
//   remain       out  ticks left in the current phase
//   rst_q        out  one-cycle realign pulse to the tick prescaler
// -----------------------------------------------------------------------------
module traffic_phase_ctrl #(
   parameter int CNT_W      = 5,
   parameter int T_MAIN_MIN = 10,
   parameter int T_SIDE     = 6,
   parameter int T_YEL      = 2,
   parameter int T_RED      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tc_timebase,
   input  logic             side_req,
   input  logic             ped_req,
`ifdef FLASH_MODE_EN
   input  logic             night_flash,
`endif
   output logic [2:0]       main_lt,
   output logic [2:0]       side_lt,
   output logic             ped_walk,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] remain,
   output logic             rst_q
);

   typedef enum logic [2:0] {
      S_MG    = 3'd0,
      S_MY    = 3'd1,
      S_R1    = 3'd2,
      S_SG    = 3'd3,
      S_SY    = 3'd4,
      S_R2    = 3'd5
`ifdef FLASH_MODE_EN
      ,S_FLASH = 3'd6
`endif
   } phase_e;

   localparam logic [CNT_W-1:0] L_MAIN = CNT_W'(T_MAIN_MIN);
   localparam logic [CNT_W-1:0] L_SIDE = CNT_W'(T_SIDE);
   localparam logic [CNT_W-1:0] L_YEL  = CNT_W'(T_YEL);
   localparam logic [CNT_W-1:0] L_RED  = CNT_W'(T_RED);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   // Lamp codes {R,Y,G}
   localparam logic [2:0] LT_R   = 3'b100;
   localparam logic [2:0] LT_Y   = 3'b010;
   localparam logic [2:0] LT_G   = 3'b001;
   localparam logic [2:0] LT_OFF = 3'b000;

   phase_e           state_q,    state_d;
   logic [CNT_W-1:0] timer_q,    timer_d;
   logic             req_pend_q, req_pend_d;
   logic [2:0]       main_lt_q,  main_lt_d;
   logic [2:0]       side_lt_q,  side_lt_d;
   logic             ped_walk_q, ped_walk_d;
   logic             realign_q,  realign_d;
   logic             flash_on_q, flash_on_d;
   logic             phase_end;

   // A tick that lands on timer==1 closes the phase. A timer of 0 cannot be
   // loaded with legal parameters, but it is treated as expired so the FSM
   // never stalls.
   assign phase_end = tc_timebase && (timer_q <= ONE);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      req_pend_d = req_pend_q | side_req | ped_req;
      realign_d  = 1'b0;
      flash_on_d = flash_on_q;

      if (tc_timebase && timer_q > ONE)
         timer_d = timer_q - ONE;

      case (state_q)
         S_MG: begin
            // The decision uses the latched request only. Without one, the
            // timer stays at 1 and green is extended.
            if (phase_end && req_pend_q) begin
               state_d = S_MY;
               timer_d = L_YEL;
            end
         end
         S_MY: if (phase_end) begin state_d = S_R1; timer_d = L_RED;  end
         S_R1: if (phase_end) begin state_d = S_SG; timer_d = L_SIDE; end
         S_SG: if (phase_end) begin state_d = S_SY; timer_d = L_YEL;  end
         S_SY: if (phase_end) begin state_d = S_R2; timer_d = L_RED;  end
         S_R2: begin
            if (phase_end) begin
`ifdef FLASH_MODE_EN
               if (night_flash) begin
                  state_d    = S_FLASH;
                  timer_d    = ONE;
                  flash_on_d = 1'b1;
               end else begin
                  state_d = S_MG;
                  timer_d = L_MAIN;
               end
`else
               state_d = S_MG;
               timer_d = L_MAIN;
`endif
            end
         end
`ifdef FLASH_MODE_EN
         S_FLASH: begin
            // The timer stays at 1 in FLASH. Only night_flash decides the
            // exit, and the exit goes through all-red clearance.
            timer_d = ONE;
            if (tc_timebase) begin
               if (!night_flash) begin
                  state_d    = S_R1;
                  timer_d    = L_RED;
                  flash_on_d = 1'b0;
               end else begin
                  flash_on_d = ~flash_on_q;
               end
            end
         end
`endif
         default: begin
            // An unreachable encoding recovers exactly as reset does.
            state_d    = S_MG;
            timer_d    = L_MAIN;
            req_pend_d = 1'b0;
            realign_d  = 1'b1;
            flash_on_d = 1'b0;
         end
      endcase

      if (state_d != state_q) begin
         realign_d = 1'b1;
         // Entry to SG serves the request. A request in the same cycle is
         // dropped, and a held request sets the latch again next cycle.
         if (state_d == S_SG)
            req_pend_d = 1'b0;
      end

      // The lamps are computed from the next phase, so they are registered
      // and change at the same edge as the phase.
      main_lt_d  = LT_G;
      side_lt_d  = LT_R;
      ped_walk_d = 1'b0;
      case (state_d)
         S_MG: begin main_lt_d = LT_G; side_lt_d = LT_R; end
         S_MY: begin main_lt_d = LT_Y; side_lt_d = LT_R; end
         S_R1,
         S_R2: begin main_lt_d = LT_R; side_lt_d = LT_R; end
         S_SG: begin main_lt_d = LT_R; side_lt_d = LT_G; ped_walk_d = 1'b1; end
         S_SY: begin main_lt_d = LT_R; side_lt_d = LT_Y; end
`ifdef FLASH_MODE_EN
         S_FLASH: begin
            main_lt_d = flash_on_d ? LT_Y : LT_OFF;
            side_lt_d = flash_on_d ? LT_R : LT_OFF;
         end
`endif
         default: begin main_lt_d = LT_G; side_lt_d = LT_R; end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_MG;
         timer_q    <= L_MAIN;
         req_pend_q <= 1'b0;
         main_lt_q  <= LT_G;
         side_lt_q  <= LT_R;
         ped_walk_q <= 1'b0;
         realign_q  <= 1'b1;
         flash_on_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         req_pend_q <= req_pend_d;
         main_lt_q  <= main_lt_d;
         side_lt_q  <= side_lt_d;
         ped_walk_q <= ped_walk_d;
         realign_q  <= realign_d;
         flash_on_q <= flash_on_d;
      end
   end

   assign main_lt  = main_lt_q;
   assign side_lt  = side_lt_q;
   assign ped_walk = ped_walk_q;
   assign phase    = state_q;
   assign remain   = timer_q;
   assign rst_q    = realign_q;

`ifndef FLASH_MODE_EN
   // Without the flash option the blink register has no use. It is tied off
   // so the default build stays free of dangling logic.
   logic unused_flash;
   assign unused_flash = flash_on_q & LT_OFF[0];
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for traffic_phase_ctrl. The driver applies one input vector
// per clock and advances a phase-table reference model. It then queues the
// outputs expected after that edge. A monitor pops the queue on every falling
// edge and compares the entry with the DUT.
// -----------------------------------------------------------------------------
module tb_traffic_phase_ctrl;

   localparam int CW = 5;
   localparam int TM = 10, TS = 6, TY = 2, TR = 1;

   logic          clk = 1'b0;
   logic          rst, tick, sreq, preq, nf;
   logic [2:0]    main_lt, side_lt, phase;
   logic          ped_walk, rst_q;
   logic [CW-1:0] remain;

   traffic_phase_ctrl #(.CNT_W(CW), .T_MAIN_MIN(TM), .T_SIDE(TS), .T_YEL(TY), .T_RED(TR)) dut (
      .clk(clk), .rst(rst), .tc_timebase(tick), .side_req(sreq), .ped_req(preq),
`ifdef FLASH_MODE_EN
      .night_flash(nf),
`endif
      .main_lt(main_lt), .side_lt(side_lt), .ped_walk(ped_walk),
      .phase(phase), .remain(remain), .rst_q(rst_q));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]    ph;
      logic [2:0]    m;
      logic [2:0]    s;
      logic          w;
      logic [CW-1:0] rem;
      logic          rq;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model state. The phase sequence is a table of
   // (phase, next phase, dwell loaded on entry to the next phase).
   int   m_ph = 0, m_tm = TM, m_fl = 0;
   bit   m_pend = 0, m_rq = 1;
   int   nxt_ph [6] = '{1, 2, 3, 4, 5, 0};
   int   nxt_dw [6] = '{TY, TR, TS, TY, TR, TM};

   function automatic exp_t expect_now();
      exp_t e;
      e.ph = 3'(m_ph); e.rem = CW'(m_tm); e.rq = m_rq; e.w = (m_ph == 3);
      case (m_ph)
         0:       begin e.m = 3'b001; e.s = 3'b100; end
         1:       begin e.m = 3'b010; e.s = 3'b100; end
         3:       begin e.m = 3'b100; e.s = 3'b001; end
         4:       begin e.m = 3'b100; e.s = 3'b010; end
         6:       begin e.m = m_fl ? 3'b010 : 3'b000; e.s = m_fl ? 3'b100 : 3'b000; end
         default: begin e.m = 3'b100; e.s = 3'b100; end
      endcase
      return e;
   endfunction

   task automatic model_edge(input bit r, input bit t, input bit s, input bit p, input bit f);
      int  old_ph;
      bit  new_pend;
      if (r) begin
         m_ph = 0; m_tm = TM; m_pend = 0; m_rq = 1; m_fl = 0;
         return;
      end
      old_ph   = m_ph;
      new_pend = m_pend | s | p;
      if (t) begin
         if (m_ph == 6) begin
            if (!f) begin m_ph = 2; m_tm = TR; m_fl = 0; end
            else m_fl = !m_fl;
         end else if (m_tm > 1) begin
            m_tm--;
         end else if (m_ph == 5 && f) begin
            m_ph = 6; m_tm = 1; m_fl = 1;
         end else if (m_ph != 0 || m_pend) begin
            m_tm = nxt_dw[m_ph];
            m_ph = nxt_ph[m_ph];
         end
      end
      m_rq = (m_ph != old_ph);
      if (m_rq && m_ph == 3) new_pend = 0;
      m_pend = new_pend;
   endtask

   // Apply one vector for the next rising edge and queue its expected result.
   task automatic step(input bit r, input bit t, input bit s, input bit p, input bit f);
      rst = r; tick = t; sreq = s; preq = p; nf = f;
      model_edge(r, t, s, p, f);
      exp_q.push_back(expect_now());
      @(posedge clk); #1;
   endtask

   // Monitor: every rising edge yields one output vector, sampled mid-cycle.
   initial begin
      exp_t e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{phase, main_lt, side_lt, ped_walk, remain, rst_q};
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL vec%0d @%0t: got ph=%0d main=%b side=%b walk=%b rem=%0d rst_q=%b, want ph=%0d main=%b side=%b walk=%b rem=%0d rst_q=%b",
                        vectors, $time, a.ph, a.m, a.s, a.w, a.rem, a.rq, e.ph, e.m, e.s, e.w, e.rem, e.rq);
            end
         end
      end
   end

   initial begin
      int ped_hold = 0;
      bit fl_req = 0;
      // Two reset cycles, then idle
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      // 15 ticks with no request: MG must count down and then hold at 1
      for (int i = 0; i < 15; i++) begin
         step(0, 1, 0, 0, 0);
         step(0, 0, 0, 0, 0);
      end
      // Side pulse, then enough ticks for a full cycle back to MG
      step(0, 0, 1, 0, 0);
      for (int i = 0; i < 26; i++) begin
         step(0, 1, 0, 0, 0);
         step(0, 0, 0, 0, 0);
      end
      // Pedestrian button held through SG entry and on into the next MG
      for (int i = 0; i < 30; i++) begin
         step(0, 1, 0, 1, 0);
         step(0, 0, 0, 1, 0);
      end
      for (int i = 0; i < 20; i++) step(0, i % 2 == 0, 0, 0, 0);
      // Reset in the middle of SG with 3 ticks remaining
      for (int i = 0; i < 200 && !(m_ph == 3 && m_tm == 3); i++)
         step(0, i % 2 == 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
`ifdef FLASH_MODE_EN
      // Enter FLASH from R2, blink for a few ticks, then leave via R1 to SG
      for (int i = 0; i < 200 && m_ph != 6; i++) step(0, i % 2 == 0, 1, 0, 1);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 0, 1);
         step(0, 0, 0, 0, 1);
      end
      for (int i = 0; i < 10; i++) step(0, i % 2 == 0, 0, 0, 0);
`endif
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit r, t, s;
         r = ($urandom_range(0, 299) == 0);
         t = ($urandom_range(0, 2) == 0);
         s = ($urandom_range(0, 29) == 0);
         if (ped_hold > 0) ped_hold--;
         else if ($urandom_range(0, 59) == 0) ped_hold = $urandom_range(1, 40);
`ifdef FLASH_MODE_EN
         if ($urandom_range(0, 199) == 0) fl_req = !fl_req;
`endif
         step(r, t, s, ped_hold > 0, fl_req);
      end
      step(0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
